// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: pointer-width function and the
// bit order of the packed status vector {uf, of, ame, amf, hf, empty, full}.
package fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int STS_FULL  = 0;
    localparam int STS_EMPTY = 1;
    localparam int STS_HF    = 2;
    localparam int STS_AMF   = 3;
    localparam int STS_AME   = 4;
    localparam int STS_OF    = 5;
    localparam int STS_UF    = 6;
    localparam int STS_W     = 7;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the FIFO: synchronous write, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int DEP = 16,
    localparam int AW = clog2(DEP)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEP];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, programmable almost flags,
// sticky overflow/underflow and optional first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int DEP = 16,
    parameter int FWFT = 0,
    localparam int AW = clog2(DEP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_en,
    input  logic [DW-1:0] data_in,
    input  logic          r_en,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          hf,
    input  logic [AW:0]   amf_th,
    input  logic [AW:0]   ame_th,
    output logic          amf,
    output logic          ame,
    input  logic          err_clr,
    output logic          of,
    output logic          uf
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d, hf_q, hf_d;
    logic          amf_q, amf_d, ame_q, ame_d, of_q, of_d, uf_q, uf_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] dout_q, dout_d, rd_data;
    logic          wr_acc, rd_acc;

    fifo_mem #(.DW(DW), .DEP(DEP)) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_comb begin
        wr_acc   = w_en & ~full_q;
        rd_acc   = r_en & ~empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // Flags come from the next count so they change on the same edge as count.
        full_d     = (count_d == (AW+1)'(DEP));
        empty_d    = (count_d == '0);
        hf_d       = (count_d >= (AW+1)'(DEP / 2));
        amf_d      = (count_d >= amf_th);
        ame_d      = (count_d <= ame_th);
        of_d       = (w_en & full_q) | (of_q & ~err_clr);
        uf_d       = (r_en & empty_q) | (uf_q & ~err_clr);
        rd_valid_d = rd_acc;
        dout_d     = rd_acc ? rd_data : dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            hf_q       <= 1'b0;
            amf_q      <= 1'b0;
            ame_q      <= 1'b1;
            of_q       <= 1'b0;
            uf_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            hf_q       <= hf_d;
            amf_q      <= amf_d;
            ame_q      <= ame_d;
            of_q       <= of_d;
            uf_q       <= uf_d;
            rd_valid_q <= rd_valid_d;
            dout_q     <= dout_d;
        end
    end

    // FWFT exposes the head word directly; standard mode uses the output register.
    assign data_out = (FWFT != 0) ? rd_data : dout_q;
    assign rd_valid = (FWFT != 0) ? ~empty_q : rd_valid_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign hf       = hf_q;
    assign amf      = amf_q;
    assign ame      = ame_q;
    assign of       = of_q;
    assign uf       = uf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: standard-mode instance plus an FWFT instance.
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int DEP = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en, r_en, err_clr;
    logic [DW-1:0] data_in;
    logic [AW:0]   amf_th, ame_th;
    logic [DW-1:0] data_out;
    logic          rd_valid, full, empty, hf, amf, ame, of, uf;
    logic [AW:0]   count;
    logic [STS_W-1:0] sts;

    logic          f_w_en, f_r_en;
    logic [DW-1:0] f_data_in, f_data_out;
    logic          f_rd_valid, f_full, f_empty, f_hf, f_amf, f_ame, f_of, f_uf;
    logic [AW:0]   f_count;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_d;

    always #5 clk = ~clk;

    sync_fifo_param #(.DW(DW), .DEP(DEP), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .rd_valid(rd_valid), .count(count), .full(full),
        .empty(empty), .hf(hf), .amf_th(amf_th), .ame_th(ame_th), .amf(amf),
        .ame(ame), .err_clr(err_clr), .of(of), .uf(uf)
    );

    sync_fifo_param #(.DW(DW), .DEP(DEP), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .w_en(f_w_en), .data_in(f_data_in), .r_en(f_r_en),
        .data_out(f_data_out), .rd_valid(f_rd_valid), .count(f_count), .full(f_full),
        .empty(f_empty), .hf(f_hf), .amf_th(amf_th), .ame_th(ame_th), .amf(f_amf),
        .ame(f_ame), .err_clr(err_clr), .of(f_of), .uf(f_uf)
    );

    always_comb begin
        sts            = '0;
        sts[STS_FULL]  = full;
        sts[STS_EMPTY] = empty;
        sts[STS_HF]    = hf;
        sts[STS_AMF]   = amf;
        sts[STS_AME]   = ame;
        sts[STS_OF]    = of;
        sts[STS_UF]    = uf;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic w, input logic [DW-1:0] d, input logic r);
        w_en = w; data_in = d; r_en = r;
        step();
        w_en = 1'b0; r_en = 1'b0;
    endtask

    // Status vector packed in the bench's bit order, built from hand values.
    function automatic logic [STS_W-1:0] mk_sts(input int c, input int amf_t, input int ame_t,
                                                 input logic o, input logic u);
        logic [STS_W-1:0] s;
        s            = '0;
        s[STS_FULL]  = (c == DEP);
        s[STS_EMPTY] = (c == 0);
        s[STS_HF]    = (c >= DEP / 2);
        s[STS_AMF]   = (c >= amf_t);
        s[STS_AME]   = (c <= ame_t);
        s[STS_OF]    = o;
        s[STS_UF]    = u;
        return s;
    endfunction

    initial begin
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; data_in = '0;
        f_w_en = 1'b0; f_r_en = 1'b0; f_data_in = '0;
        amf_th = 5'd14; ame_th = 5'd2;
        step(); step();
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_sts", 32'(sts), 32'(mk_sts(0, 14, 2, 0, 0)));
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_data_out", 32'(data_out), 0);

        for (int i = 0; i < 16; i++) begin
            op(1'b1, DW'(8'h10 + i), 1'b0);
            exp_q.push_back(DW'(8'h10 + i));
            chk($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
            chk($sformatf("fill_sts%0d", i), 32'(sts), 32'(mk_sts(i + 1, 14, 2, 0, 0)));
            chk($sformatf("fill_rdv%0d", i), 32'(rd_valid), 0);
        end

        op(1'b1, 8'hAA, 1'b0);
        chk("ovf_of", 32'(of), 1);
        chk("ovf_count", 32'(count), 16);
        step();
        chk("ovf_sticky", 32'(of), 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("ovf_cleared", 32'(of), 0);

        // Full with simultaneous write/read: read wins, write rejected (and flags overflow).
        op(1'b1, 8'hBB, 1'b1);
        exp_d = exp_q.pop_front();
        chk("fullrw_count", 32'(count), 15);
        chk("fullrw_full", 32'(full), 0);
        chk("fullrw_data", 32'(data_out), 32'(exp_d));
        chk("fullrw_rdv", 32'(rd_valid), 1);
        chk("fullrw_of", 32'(of), 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("fullrw_hold_data", 32'(data_out), 32'(exp_d));
        chk("fullrw_hold_rdv", 32'(rd_valid), 0);

        for (int i = 0; i < 7; i++) begin
            op(1'b0, '0, 1'b1);
            exp_d = exp_q.pop_front();
            chk($sformatf("trim_data%0d", i), 32'(data_out), 32'(exp_d));
        end
        chk("half_count", 32'(count), 8);
        chk("half_hf", 32'(hf), 1);

        for (int i = 0; i < 20; i++) begin
            op(1'b1, DW'(8'h20 + i), 1'b1);
            exp_q.push_back(DW'(8'h20 + i));
            exp_d = exp_q.pop_front();
            chk($sformatf("wrap_data%0d", i), 32'(data_out), 32'(exp_d));
            chk($sformatf("wrap_count%0d", i), 32'(count), 8);
        end

        for (int i = 0; i < 8; i++) begin
            op(1'b0, '0, 1'b1);
            exp_d = exp_q.pop_front();
            chk($sformatf("drain_data%0d", i), 32'(data_out), 32'(exp_d));
            chk($sformatf("drain_sts%0d", i), 32'(sts), 32'(mk_sts(7 - i, 14, 2, 0, 0)));
        end
        chk("drain_last", 32'(data_out), 32'h33);

        op(1'b0, '0, 1'b1);
        chk("udf_uf", 32'(uf), 1);
        chk("udf_count", 32'(count), 0);
        chk("udf_data_hold", 32'(data_out), 32'h33);
        chk("udf_rdv", 32'(rd_valid), 0);
        // Set beats clear when both happen in the same cycle.
        err_clr = 1'b1; r_en = 1'b1; step(); r_en = 1'b0;
        chk("udf_set_wins", 32'(uf), 1);
        step(); err_clr = 1'b0;
        chk("udf_cleared", 32'(uf), 0);

        amf_th = 5'd0; step();
        chk("th_amf_change", 32'(amf), 1);
        amf_th = 5'd14; step();
        chk("th_amf_back", 32'(amf), 0);

        // Reset mid-operation discards contents and ignores w_en.
        op(1'b1, 8'h77, 1'b0);
        op(1'b1, 8'h78, 1'b0);
        rst = 1'b1; w_en = 1'b1; data_in = 8'h99; step(); w_en = 1'b0; rst = 1'b0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_sts", 32'(sts), 32'(mk_sts(0, 14, 2, 0, 0)));
        chk("midrst_data", 32'(data_out), 0);

        // FWFT instance.
        chk("f_rst_empty", 32'(f_empty), 1);
        chk("f_rst_rdv", 32'(f_rd_valid), 0);
        f_w_en = 1'b1; f_data_in = 8'h5A; step(); f_w_en = 1'b0;
        chk("f_data_5a", 32'(f_data_out), 32'h5A);
        chk("f_rdv", 32'(f_rd_valid), 1);
        chk("f_count1", 32'(f_count), 1);
        step();
        chk("f_data_steady", 32'(f_data_out), 32'h5A);
        f_r_en = 1'b1; step(); f_r_en = 1'b0;
        chk("f_pop_empty", 32'(f_empty), 1);
        chk("f_pop_rdv", 32'(f_rd_valid), 0);
        f_w_en = 1'b1; f_data_in = 8'hC1; step();
        f_data_in = 8'hC2; step(); f_w_en = 1'b0;
        chk("f_head1", 32'(f_data_out), 32'hC1);
        f_r_en = 1'b1; step();
        chk("f_head2", 32'(f_data_out), 32'hC2);
        chk("f_count_after_pop", 32'(f_count), 1);
        step(); f_r_en = 1'b0;
        chk("f_empty_end", 32'(f_empty), 1);
        chk("f_uf_clear", 32'(f_uf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
